envia_movimentos: RTL and testbench

Reads the solution move list from the movement memory and transmits it as 8N1 serial frames to the robot controller. It is the sending end of the link on which the capture side receives moves, driving the same byte format in the opposite direction. The block contains its own control FSM, address counter, baud timer and shift register, and it stops on a terminator byte or after a fixed move count.

---
 rtl/envia_movimentos.sv | 154 +++++++++++++++
 tb/tb_envia_movimentos.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/envia_movimentos.sv
// envia_movimentos: reads the solution move list from the movement memory and sends each byte as a
// serial frame, stopping on an 8'hFF terminator or after N_MOV moves. Define ENVIA_MOVIMENTOS_PARIDADE_EN for 8E1 frames.
module envia_movimentos #(
  parameter int unsigned BAUD_DIV = 434,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned N_MOV    = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              iniciar,
  input  logic [7:0]        dado_movimento,
  output logic [ADDR_W-1:0] addr_movimento,
  output logic              saida_serial,
  output logic              ocupado,
  output logic              pronto,
  output logic [ADDR_W:0]   enviados,
  output logic [2:0]        db_estado
);

  localparam int unsigned CNT_W  = ADDR_W + 1;
  localparam int unsigned BAUD_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
`ifdef ENVIA_MOVIMENTOS_PARIDADE_EN
  localparam int unsigned FRAME_BITS = 11;
`else
  localparam int unsigned FRAME_BITS = 10;
`endif
  localparam int unsigned BIT_W = $clog2(FRAME_BITS);
  localparam logic [7:0]  TERMINADOR = 8'hFF;

  typedef enum logic [2:0] {
    INICIAL     = 3'b000,
    PREPARACAO  = 3'b001,
    LE_MEMORIA  = 3'b010,
    ESPERA_DADO = 3'b011,
    TRANSMITE   = 3'b100,
    PROXIMO     = 3'b101,
    FIM         = 3'b110
  } estado_t;

  estado_t               estado;
  estado_t               prox_estado;
  logic [BAUD_W-1:0]     baud_cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic [FRAME_BITS-1:0] quadro;
  logic [FRAME_BITS-1:0] quadro_novo;
  logic                  fim_bit;
  logic                  fim_quadro;
  logic                  ultimo_end;
  logic                  zera;
  logic                  carrega;
  logic                  transmitindo;
  logic                  avanca;

  // Frame is shifted out from bit 0: start, data LSB first, [parity], stop.
`ifdef ENVIA_MOVIMENTOS_PARIDADE_EN
  assign quadro_novo = {1'b1, ^dado_movimento, dado_movimento, 1'b0};
`else
  assign quadro_novo = {1'b1, dado_movimento, 1'b0};
`endif

  assign fim_bit    = (baud_cnt == BAUD_W'(BAUD_DIV - 1));
  assign fim_quadro = fim_bit && (bit_cnt == BIT_W'(FRAME_BITS - 1));
  assign ultimo_end = (addr_movimento == ADDR_W'(N_MOV - 1));
  assign db_estado  = estado;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) estado <= INICIAL;
    else        estado <= prox_estado;
  end

  // Next state and datapath strobes.
  always_comb begin
    prox_estado  = estado;
    zera         = 1'b0;
    carrega      = 1'b0;
    transmitindo = 1'b0;
    avanca       = 1'b0;
    case (estado)
      INICIAL:     if (iniciar) prox_estado = PREPARACAO;
      PREPARACAO: begin
        zera        = 1'b1;
        prox_estado = LE_MEMORIA;
      end
      LE_MEMORIA:  prox_estado = ESPERA_DADO;
      ESPERA_DADO: begin
        if (dado_movimento == TERMINADOR) begin
          prox_estado = FIM;
        end else begin
          carrega     = 1'b1;
          prox_estado = TRANSMITE;
        end
      end
      TRANSMITE: begin
        transmitindo = 1'b1;
        if (fim_quadro) prox_estado = PROXIMO;
      end
      PROXIMO: begin
        avanca      = 1'b1;
        prox_estado = ultimo_end ? FIM : LE_MEMORIA;
      end
      FIM:         prox_estado = INICIAL;
      default:     prox_estado = INICIAL;
    endcase
  end

  // Status flags are registered from the next state so they line up with the state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ocupado <= 1'b0;
      pronto  <= 1'b0;
    end else begin
      ocupado <= (prox_estado != INICIAL);
      pronto  <= (prox_estado == FIM);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      addr_movimento <= '0;
      enviados       <= '0;
    end else if (zera) begin
      addr_movimento <= '0;
      enviados       <= '0;
    end else if (avanca) begin
      enviados <= enviados + CNT_W'(1);
      if (!ultimo_end) addr_movimento <= addr_movimento + ADDR_W'(1);
    end
  end

  // Baud timer and shift register; the line goes low on the first TRANSMITE cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      quadro       <= '1;
      baud_cnt     <= '0;
      bit_cnt      <= '0;
      saida_serial <= 1'b1;
    end else if (carrega) begin
      quadro       <= quadro_novo;
      baud_cnt     <= '0;
      bit_cnt      <= '0;
      saida_serial <= 1'b0;
    end else if (transmitindo) begin
      if (fim_bit) begin
        baud_cnt     <= '0;
        bit_cnt      <= bit_cnt + BIT_W'(1);
        quadro       <= {1'b1, quadro[FRAME_BITS-1:1]};
        saida_serial <= fim_quadro ? 1'b1 : quadro[1];
      end else begin
        baud_cnt <= baud_cnt + BAUD_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_envia_movimentos.sv
// Testbench for envia_movimentos: compares the serial line and status outputs cycle by cycle
// against a waveform built from the frame rules, with randomized move lists.
module tb_envia_movimentos;

  localparam int unsigned B  = 8;
  localparam int unsigned AW = 5;
  localparam int unsigned NM = 32;
`ifdef ENVIA_MOVIMENTOS_PARIDADE_EN
  localparam int unsigned FB = 11;
`else
  localparam int unsigned FB = 10;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          iniciar = 1'b0;
  logic [7:0]    dado_movimento = 8'h00;
  logic [AW-1:0] addr_movimento;
  logic          saida_serial;
  logic          ocupado;
  logic          pronto;
  logic [AW:0]   enviados;
  logic [2:0]    db_estado;

  logic [7:0] mem [NM];
  logic       exp_line [$];
  logic       seen [$];
  int         exp_fim;
  int         exp_env;
  int         max_addr;
  int         compared = 0;
  int         mismatched = 0;

  envia_movimentos #(.BAUD_DIV(B), .ADDR_W(AW), .N_MOV(NM)) dut (
    .clock          (clock),
    .reset          (reset),
    .iniciar        (iniciar),
    .dado_movimento (dado_movimento),
    .addr_movimento (addr_movimento),
    .saida_serial   (saida_serial),
    .ocupado        (ocupado),
    .pronto         (pronto),
    .enviados       (enviados),
    .db_estado      (db_estado)
  );

  always #5 clock = ~clock;

  // Synchronous-read movement memory, one cycle of latency.
  always @(posedge clock) dado_movimento <= mem[addr_movimento];

  task automatic push_frame(input logic [7:0] b);
    logic bits [$];
    bits.push_back(1'b0);
    for (int k = 0; k < 8; k++) bits.push_back(b[k]);
`ifdef ENVIA_MOVIMENTOS_PARIDADE_EN
    bits.push_back(^b);
`endif
    bits.push_back(1'b1);
    foreach (bits[k]) repeat (B) exp_line.push_back(bits[k]);
  endtask

  // Expected line from iniciar onward: 3 setup cycles, then frame + 3 idle cycles per move.
  task automatic build_model();
    int  n = 0;
    bit  term = 1'b0;
    exp_line.delete();
    repeat (3) exp_line.push_back(1'b1);
    for (int i = 0; i < NM; i++) begin
      if (mem[i] == 8'hFF) begin
        term = 1'b1;
        break;
      end
      push_frame(mem[i]);
      repeat (3) exp_line.push_back(1'b1);
      n++;
    end
    exp_env = n;
    exp_fim = term ? exp_line.size() + 1 : exp_line.size() - 1;
  endtask

  task automatic run_request(input string name, input int busy_at);
    bit   bad_line = 1'b0, bad_pronto = 1'b0, bad_ocup = 1'b0;
    logic exp_l;
    int   n_pronto = 0;
    build_model();
    seen.delete();
    max_addr = 0;
    @(negedge clock) iniciar = 1'b1;
    for (int c = 1; c <= exp_fim + 3; c++) begin
      @(negedge clock);
      iniciar = (c == busy_at);
      exp_l = (c <= exp_line.size()) ? exp_line[c-1] : 1'b1;
      seen.push_back(saida_serial);
      if (int'(addr_movimento) > max_addr) max_addr = int'(addr_movimento);
      if (pronto === 1'b1) n_pronto++;
      if (saida_serial !== exp_l && !bad_line) begin
        bad_line = 1'b1; mismatched++;
        $display("FAIL %s line cycle %0d: got %b want %b", name, c, saida_serial, exp_l);
      end
      if (pronto !== (c == exp_fim) && !bad_pronto) begin
        bad_pronto = 1'b1; mismatched++;
        $display("FAIL %s pronto cycle %0d: got %b want %b", name, c, pronto, (c == exp_fim));
      end
      if (ocupado !== (c <= exp_fim) && !bad_ocup) begin
        bad_ocup = 1'b1; mismatched++;
        $display("FAIL %s ocupado cycle %0d: got %b want %b", name, c, ocupado, (c <= exp_fim));
      end
      if (c == exp_fim) begin
        compared += 2;
        if (enviados !== (AW+1)'(exp_env)) begin
          mismatched++;
          $display("FAIL %s enviados: got %0d want %0d", name, enviados, exp_env);
        end
        if (db_estado !== 3'b110) begin
          mismatched++;
          $display("FAIL %s db_estado fim: got %b want 110", name, db_estado);
        end
      end
      if (c == exp_fim + 1) begin
        compared++;
        if (db_estado !== 3'b000) begin
          mismatched++;
          $display("FAIL %s db_estado after fim: got %b want 000", name, db_estado);
        end
      end
    end
    compared += 4;
    if (n_pronto != 1) begin
      mismatched++;
      $display("FAIL %s pronto pulses: got %0d want 1", name, n_pronto);
    end
  endtask

  task automatic test_reset();
    #3 reset = 1'b0;
    #1;
    compared++;
    if ({saida_serial, ocupado, pronto, db_estado} !== 6'b100000 ||
        addr_movimento !== '0 || enviados !== '0) begin
      mismatched++;
      $display("FAIL reset outputs: got line=%b ocup=%b pronto=%b est=%b addr=%0d env=%0d want 1 0 0 000 0 0",
               saida_serial, ocupado, pronto, db_estado, addr_movimento, enviados);
    end
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    compared++;
    if (ocupado !== 1'b0 || saida_serial !== 1'b1) begin
      mismatched++;
      $display("FAIL idle after reset: got ocup=%b line=%b want 0 1", ocupado, saida_serial);
    end
  endtask

  task automatic test_single_move();
    logic expb [10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    bit   ok = 1'b1;
    for (int i = 0; i < NM; i++) mem[i] = 8'h11;
    mem[0] = 8'h23;
    mem[1] = 8'hFF;
    run_request("single", -1);
    for (int k = 0; k < 9; k++) if (seen[3 + k*B + B/2] !== expb[k]) ok = 1'b0;
    if (seen[3 + (FB-1)*B + B/2] !== expb[9]) ok = 1'b0;
    compared++;
    if (!ok) begin
      mismatched++;
      $display("FAIL single frame bits for 8'h23: got wrong mid-bit samples want 0110001001");
    end
  endtask

  task automatic test_terminator();
    bit low = 1'b0;
    for (int i = 0; i < NM; i++) mem[i] = 8'h55;
    mem[0] = 8'hFF;
    run_request("term0", -1);
    foreach (seen[k]) if (seen[k] !== 1'b1) low = 1'b1;
    compared++;
    if (low) begin
      mismatched++;
      $display("FAIL term0 start bit seen: got low line want always high");
    end
  endtask

  task automatic test_full_list();
    for (int i = 0; i < NM; i++) mem[i] = 8'(i);
    run_request("full", -1);
    compared += 2;
    if (enviados !== 6'd32) begin
      mismatched++;
      $display("FAIL full enviados: got %0d want 32", enviados);
    end
    if (max_addr != NM - 1) begin
      mismatched++;
      $display("FAIL full max addr: got %0d want %0d", max_addr, NM - 1);
    end
  endtask

  task automatic test_busy();
    for (int i = 0; i < 3; i++) mem[i] = 8'($urandom_range(0, 254));
    mem[3] = 8'hFF;
    run_request("busy", 3 + (FB*B + 3) + (FB*B)/2);
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < NM; i++) mem[i] = 8'hFF;
    mem[0] = 8'hA5;
    mem[1] = 8'h3C;
    @(negedge clock) iniciar = 1'b1;
    @(negedge clock) iniciar = 1'b0;
    repeat (3 + 4*B + B/2) @(negedge clock);
    compared++;
    if (db_estado !== 3'b100) begin
      mismatched++;
      $display("FAIL midreset not transmitting: got %b want 100", db_estado);
    end
    reset = 1'b0;
    #1;
    compared++;
    if (saida_serial !== 1'b1 || db_estado !== 3'b000 || ocupado !== 1'b0 ||
        addr_movimento !== '0 || enviados !== '0) begin
      mismatched++;
      $display("FAIL midreset outputs: got line=%b est=%b ocup=%b addr=%0d env=%0d want 1 000 0 0 0",
               saida_serial, db_estado, ocupado, addr_movimento, enviados);
    end
    @(negedge clock) reset = 1'b1;
    mem[0] = 8'h5A;
    mem[1] = 8'hFF;
    run_request("after_reset", -1);
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      int n = $urandom_range(0, 6);
      for (int i = 0; i < NM; i++) mem[i] = 8'($urandom_range(0, 255));
      for (int i = 0; i < n; i++) mem[i] = 8'($urandom_range(0, 254));
      mem[n] = 8'hFF;
      run_request($sformatf("random%0d", it), -1);
    end
  endtask

`ifdef ENVIA_MOVIMENTOS_PARIDADE_EN
  task automatic test_parity();
    logic expb [11] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    bit   ok = 1'b1;
    mem[0] = 8'h07;
    mem[1] = 8'hFF;
    run_request("parity", -1);
    for (int k = 0; k < 11; k++) if (seen[3 + k*B + B/2] !== expb[k]) ok = 1'b0;
    if (seen[3 + 11*B] !== 1'b1 || seen[3 + 11*B - 1] !== 1'b1) ok = 1'b0;
    compared++;
    if (!ok) begin
      mismatched++;
      $display("FAIL parity frame for 8'h07: got wrong samples want 01110000011");
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < NM; i++) mem[i] = 8'hFF;
    test_reset();
    test_single_move();
    test_terminator();
    test_full_list();
    test_busy();
    test_mid_reset();
    test_random();
`ifdef ENVIA_MOVIMENTOS_PARIDADE_EN
    test_parity();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
